i2s_rx_deserializer: RTL and testbench

I2S_RX_DESERIALIZER -- requirements
Module: i2s_rx_deserializer

---
 rtl/i2s_rx_deserializer.sv | 193 +++++++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
//   Receives a stereo I2S stream (bclk/lrck/adcdat from a codec running
//   asynchronously to clk) and presents each complete left+right frame as a
//   pair of signed WIDTH-bit samples with a valid/ready handshake.
//
// Parameters
//   WIDTH        sample width per channel (FIR input width)
//   SYNC_STAGES  synchronizer depth on each codec input (minimum 2)
//
// Ports
//   clk          system clock, must run at least 4x bclk
//   reset_n      asynchronous active-low reset
//   bclk         codec bit clock (asynchronous)
//   lrck         codec word select, 0 = left, 1 = right
//   adcdat       codec serial data, MSB first
//   left_q       signed left sample
//   right_q      signed right sample
//   out_valid    left_q/right_q hold an unconsumed pair
//   out_ready    consumer accepts the pair when out_valid is also 1
//   overrun      (I2S_RX_OVERRUN_EN only) sticky: an unconsumed pair was overwritten
//   overrun_clr  (I2S_RX_OVERRUN_EN only) clears overrun; a coincident set wins
//
// Build option
//   `define I2S_RX_OVERRUN_EN to add the overrun/overrun_clr ports.
`timescale 1ns/1ps

module i2s_rx_deserializer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    bclk,
    input  logic                    lrck,
    input  logic                    adcdat,
    output logic signed [WIDTH-1:0] left_q,
    output logic signed [WIDTH-1:0] right_q,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef I2S_RX_OVERRUN_EN
    ,
    output logic                    overrun,
    input  logic                    overrun_clr
`endif
);

    localparam logic [1:0] ALIGN = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] PAD   = 2'd3;

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] adc_sync_q;
    logic                   bclk_prev_q;

    logic             bclk_s, lrck_s, adc_s, bit_en, lr_chg;
    logic [1:0]       state_q, state_d;
    logic             chan_q, chan_d;
    logic             lr_prev_q, lr_prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;   // one-hot shift counter: next bit position
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hold_q;
    logic             pair_done_q;
    logic             word_done;

    // Synchronizers and bclk edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            adc_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
            adc_sync_q  <= {adc_sync_q[SYNC_STAGES-2:0], adcdat};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign adc_s  = adc_sync_q[SYNC_STAGES-1];
    assign bit_en = bclk_s & ~bclk_prev_q;
    assign lr_chg = lrck_s ^ lr_prev_q;

    // Frame FSM. The bit sampled together with an lrck change is the LSB slot
    // of the word just ending (the I2S one-bit delay of the new channel), so
    // SHIFT takes it before closing the word and it never reaches the new one.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        lr_prev_d = lr_prev_q;
        mask_d    = mask_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        if (bit_en) begin
            lr_prev_d = lrck_s;
        end
        case (state_q)
            ALIGN: begin
                if (bit_en && lr_prev_q && !lrck_s) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                // Another lrck change here restarts DELAY for the new channel.
                if (!(bit_en && lr_chg)) begin
                    chan_d  = lr_prev_q;
                    mask_d  = {1'b1, {(WIDTH-1){1'b0}}};
                    sr_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (adc_s) begin
                        sr_d = sr_q | mask_q;
                    end
                    mask_d = mask_q >> 1;
                    // Short words end here already left-justified: sr was
                    // cleared and unfilled LSBs stay zero.
                    if (lr_chg) begin
                        word_done = 1'b1;
                        state_d   = DELAY;
                    end else if (mask_q[0]) begin
                        word_done = 1'b1;
                        state_d   = PAD;
                    end
                end
            end
            PAD: begin
                if (bit_en && lr_chg) begin
                    state_d = DELAY;
                end
            end
            default: state_d = ALIGN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ALIGN;
            chan_q      <= 1'b0;
            lr_prev_q   <= 1'b0;
            mask_q      <= '0;
            sr_q        <= '0;
            hold_q      <= '0;
            pair_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            lr_prev_q   <= lr_prev_d;
            mask_q      <= mask_d;
            sr_q        <= sr_d;
            if (word_done && !chan_q) begin
                hold_q <= sr_d;
            end
            pair_done_q <= word_done & chan_q;
        end
    end

    // Output register: sr_q still holds the right word one cycle after it
    // finishes, even if DELAY clears it on this same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_q    <= '0;
            right_q   <= '0;
            out_valid <= 1'b0;
        end else if (pair_done_q) begin
            left_q    <= hold_q;
            right_q   <= sr_q;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    logic overrun_set;
    assign overrun_set = pair_done_q & out_valid & ~out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun_set | (overrun & ~overrun_clr);
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
`timescale 1ns/1ps

module tb_i2s_rx_deserializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bclk = 1'b0;
    logic        lrck = 1'b0;
    logic        adcdat = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] left_q;
    logic [15:0] right_q;
    logic        out_valid;
`ifdef I2S_RX_OVERRUN_EN
    logic        overrun;
    logic        overrun_clr = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cap_cnt = 0;
    int          valid_low = 0;
    logic [15:0] cap_left = '0;
    logic [15:0] cap_right = '0;
    logic        tail = 1'b0;
    logic [31:0] r;

    always #10 clk = ~clk;   // 50 MHz

    i2s_rx_deserializer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bclk      (bclk),
        .lrck      (lrck),
        .adcdat    (adcdat),
        .left_q    (left_q),
        .right_q   (right_q),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef I2S_RX_OVERRUN_EN
        ,
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`endif
    );

    // Records every cycle the output is presented.
    always @(negedge clk) begin
        if (out_valid) begin
            cap_cnt   = cap_cnt + 1;
            cap_left  = left_q;
            cap_right = right_q;
        end else begin
            valid_low = valid_low + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bclk period = 16 clk; data changes while bclk is low.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        bclk = 1'b0; lrck = lr; adcdat = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    // One lrck slot: first bit carries the previous word's LSB (I2S delay).
    task automatic send_slot(input logic lr, input logic [31:0] w, input int n);
        send_bit(lr, tail);
        for (int i = n - 1; i >= 1; i--) send_bit(lr, w[i]);
        tail = w[0];
    endtask

    task automatic do_reset();
        reset_n = 1'b0; bclk = 1'b0; lrck = 1'b0; adcdat = 1'b0; tail = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        cap_cnt = 0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_left", 32'(left_q), 32'h0);
        chk("rst_right", 32'(right_q), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
`ifdef I2S_RX_OVERRUN_EN
        chk("rst_overrun", 32'(overrun), 32'h0);
`endif
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        cap_cnt = 0;

        // 32-bit words, ready tied high: one pulse
        out_ready = 1'b1;
        send_slot(1'b1, 32'h0, 32);
        send_slot(1'b0, 32'h8001_1234, 32);
        send_slot(1'b1, 32'h7FFE_FFFF, 32);
        repeat (10) @(negedge clk);
        chk("w32_pulses", 32'(cap_cnt), 32'd1);
        chk("w32_left", 32'(cap_left), 32'h8001);
        chk("w32_right", 32'(cap_right), 32'h7FFE);
        chk("w32_valid_clr", 32'(out_valid), 32'h0);

        // Short 12-bit words: left-justified
        do_reset();
        send_slot(1'b1, 32'h0, 12);
        send_slot(1'b0, 32'hABC, 12);
        send_slot(1'b1, 32'h123, 12);
        send_bit(1'b0, tail);
        repeat (10) @(negedge clk);
        chk("w12_pulses", 32'(cap_cnt), 32'd1);
        chk("w12_left", 32'(cap_left), 32'hABC0);
        chk("w12_right", 32'(cap_right), 32'h1230);

        // Reset released in the middle of a right word
        reset_n = 1'b0; tail = 1'b0;
        send_slot(1'b1, 32'h0, 32);
        send_slot(1'b0, 32'hDEAD_BEEF, 32);
        r = 32'hCAFE_0000;
        send_bit(1'b1, tail);
        for (int i = 31; i >= 20; i--) send_bit(1'b1, r[i]);
        reset_n = 1'b1;
        cap_cnt = 0;
        for (int i = 19; i >= 1; i--) send_bit(1'b1, r[i]);
        tail = r[0];
        chk("mid_no_output", 32'(cap_cnt), 32'd0);
        send_slot(1'b0, 32'h5555_0000, 32);
        send_slot(1'b1, 32'h0F0F_0000, 32);
        repeat (10) @(negedge clk);
        chk("mid_pulses", 32'(cap_cnt), 32'd1);
        chk("mid_left", 32'(cap_left), 32'h5555);
        chk("mid_right", 32'(cap_right), 32'h0F0F);

        // Ready held low across two frames: latest wins
        do_reset();
        out_ready = 1'b0;
        send_slot(1'b1, 32'h0, 32);
        send_slot(1'b0, 32'h1111_0000, 32);
        send_slot(1'b1, 32'h2222_0000, 32);
        repeat (4) @(negedge clk);
        chk("ovr_a_valid", 32'(out_valid), 32'h1);
        chk("ovr_a_left", 32'(left_q), 32'h1111);
        chk("ovr_a_right", 32'(right_q), 32'h2222);
`ifdef I2S_RX_OVERRUN_EN
        chk("ovr_a_flag", 32'(overrun), 32'h0);
`endif
        send_slot(1'b0, 32'h3333_0000, 32);
        send_slot(1'b1, 32'h4444_0000, 32);
        repeat (4) @(negedge clk);
        chk("ovr_b_valid", 32'(out_valid), 32'h1);
        chk("ovr_b_left", 32'(left_q), 32'h3333);
        chk("ovr_b_right", 32'(right_q), 32'h4444);
`ifdef I2S_RX_OVERRUN_EN
        chk("ovr_b_flag", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);
`endif

        // Ready pulsed exactly on the edge a new pair loads (16-bit slots)
        send_slot(1'b0, 32'h5A5A, 16);
        send_slot(1'b1, 32'hA5A5, 16);
        valid_low = 0;
        @(negedge clk);
        bclk = 1'b0; lrck = 1'b0; adcdat = tail;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        // 2 sync edges, 1 sample edge, then the load edge
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        #4;
        chk("coin_valid", 32'(out_valid), 32'h1);
        chk("coin_left", 32'(left_q), 32'h5A5A);
        chk("coin_right", 32'(right_q), 32'hA5A5);
        chk("coin_no_gap", 32'(valid_low), 32'd0);
`ifdef I2S_RX_OVERRUN_EN
        chk("coin_flag", 32'(overrun), 32'h0);
`endif

        // Asynchronous reset between clk edges
        @(posedge clk);
        #4 reset_n = 1'b0;
        #2;
        chk("async_left", 32'(left_q), 32'h0);
        chk("async_right", 32'(right_q), 32'h0);
        chk("async_valid", 32'(out_valid), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
